// File: rtl/bz_melody_seq.sv
// Melody sequencer: walks a song ROM ({tune, len} per entry) and plays each note for len beats.
// Define BZ_MELODY_GAP_EN to insert a silent articulation gap at the end of every note.
`timescale 1ns/1ps
module bz_melody_seq #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BEAT_CYCLES = 3_125_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int SONG_LEN    = 64,
  localparam int ADDR_W     = $clog2(SONG_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        tune,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SONG_LEN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef BZ_MELODY_GAP_EN
  localparam logic [2:0] S_GAP    = 3'd4;
  // The gap reuses the tail of the last beat, so the note period stays len beats.
  localparam logic [BEAT_W-1:0] PLAY_LAST = BEAT_W'(BEAT_CYCLES - GAP_CYCLES - 1);
`endif

  if (BEAT_CYCLES <= GAP_CYCLES || CLK_HZ <= 0) begin : g_bad_cfg
    $error("bz_melody_seq: BEAT_CYCLES must exceed GAP_CYCLES and CLK_HZ must be positive");
  end

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        tune_q, tune_d;
  logic [7:0]        len_q, len_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [7:0]        unit_q, unit_d;
  logic              beat_wrap, last_unit, adv, end_hit;

  assign beat_wrap = (beat_q == BEAT_LAST);
  assign last_unit = (unit_q == len_q - 8'd1);

  always_comb begin
    // NOTE: every _d defaults to its _q (and flags to 0) so no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    tune_d  = tune_q;
    len_d   = len_q;
    beat_d  = beat_q;
    unit_d  = unit_q;
    adv     = 1'b0;
    end_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data[7:0] == 8'd0) begin
          end_hit = 1'b1;
        end else begin
          tune_d  = rom_data[15:8];
          len_d   = rom_data[7:0];
          beat_d  = '0;
          unit_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        beat_d = beat_wrap ? '0 : beat_q + BEAT_W'(1);
        unit_d = beat_wrap ? unit_q + 8'd1 : unit_q;
`ifdef BZ_MELODY_GAP_EN
        if (last_unit && beat_q == PLAY_LAST) state_d = S_GAP;
`else
        if (last_unit && beat_wrap) adv = 1'b1;
`endif
      end
`ifdef BZ_MELODY_GAP_EN
      S_GAP: begin
        beat_d = beat_wrap ? '0 : beat_q + BEAT_W'(1);
        unit_d = beat_wrap ? unit_q + 8'd1 : unit_q;
        if (beat_wrap) adv = 1'b1;
      end
`endif
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completing the last ROM slot ends the song exactly like a sentinel would.
    if (adv) begin
      if (idx_q == IDX_LAST) begin
        end_hit = 1'b1;
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    if (end_hit) begin
      if (loop_en) begin
        idx_d   = '0;
        state_d = S_FETCH;
      end else begin
        state_d = S_DONE;
      end
    end

    // stop overrides everything, including a simultaneous start.
    if (stop) begin
      idx_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tune_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      unit_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tune_q  <= tune_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      unit_q  <= unit_d;
    end
  end

  assign rom_addr = idx_q;
  assign tune     = (state_q == S_PLAY) ? tune_q : 8'h00;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_bz_melody_seq.sv
// Self-checking bench for bz_melody_seq: a note-level song model predicts every output cycle.
`timescale 1ns/1ps
module tb_bz_melody_seq;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int SLEN = 4;
  localparam int AW   = $clog2(SLEN);
`ifdef BZ_MELODY_GAP_EN
  localparam int MGAP    = GAP;
  localparam int L_END11 = 30;
  localparam int L_END25 = 42;
`else
  localparam int MGAP    = 0;
  localparam int L_END11 = 32;
  localparam int L_END25 = 44;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop, loop_en;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    tune;
  logic          busy, done;
  logic [15:0]   rom [SLEN];

  typedef struct packed {
    logic [7:0]    tune;
    logic          busy;
    logic          done;
    logic          addr_chk;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  bit   chk_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  bz_melody_seq #(
    .CLK_HZ(50_000_000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .tune(tune), .busy(busy), .done(done)
  );

  function automatic exp_t mk(logic [7:0] t, logic b, logic d, logic ac, logic [AW-1:0] a);
    exp_t e;
    e.tune = t; e.busy = b; e.done = d; e.addr_chk = ac; e.addr = a;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Song timeline: per entry 2 silent fetch cycles, then len beats minus the gap audible,
  // then the gap silent. 'loops' counts how many song ends restart before the final DONE.
  task automatic model_song(int loops);
    int pass = 0;
    int len;
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, '0));
    forever begin
      for (int i = 0; i < SLEN; i++) begin
        len = int'(rom[i][7:0]);
        exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1, AW'(i)));
        exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, '0));
        if (len == 0) break;
        repeat (len * BEAT - MGAP) exp_q.push_back(mk(rom[i][15:8], 1'b1, 1'b0, 1'b0, '0));
        repeat (MGAP) exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, '0));
      end
      if (pass == loops) break;
      pass++;
    end
    exp_q.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, '0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(8'h00, 1'b0, 1'b0, 1'b1, '0);
      check("tune_busy_done", {22'd0, tune, busy, done}, {22'd0, e.tune, e.busy, e.done});
      if (e.addr_chk) check("rom_addr", 32'(rom_addr), 32'(e.addr));
      if (done) done_cnt++;
    end
  end

  task automatic set_rom(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic do_start(int loops);
    @(posedge clk); #1 start = 1'b1;
    model_song(loops);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1 stop = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic pulse(logic s, logic p);
    @(posedge clk); #1 start = s; stop = p;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(string name, int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d model cycles still pending after %0d cycles",
               name, exp_q.size(), max_cycles);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; loop_en = 1'b0;

    // Pin the model to the hand-derived timelines before using it.
    set_rom(16'h1103, 16'h2501, 16'h0002, 16'h0000);
    model_song(0);
    check("pin_first_11", 32'(exp_q[3].tune), 32'h11);
    check("pin_last_11",  32'(exp_q[L_END11].tune), 32'h11);
    check("pin_after_11", 32'(exp_q[L_END11 + 1].tune), 32'h00);
    check("pin_pre_25",   32'(exp_q[34].tune), 32'h00);
    check("pin_first_25", 32'(exp_q[35].tune), 32'h25);
    check("pin_last_25",  32'(exp_q[L_END25].tune), 32'h25);
    check("pin_after_25", 32'(exp_q[L_END25 + 1].tune), 32'h00);
    check("pin_done_cyc", 32'(exp_q[69].done), 32'd1);
    check("pin_len",      32'(exp_q.size()), 32'd70);
    exp_q.delete();
    model_song(1);
    check("pin_loop_addr", 32'({exp_q[69].addr_chk, exp_q[69].addr}), 32'({1'b1, 2'd0}));
    check("pin_loop_11",   32'(exp_q[71].tune), 32'h11);
    check("pin_loop_len",  32'(exp_q.size()), 32'd138);
    exp_q.delete();

    // Reset held for three edges with start asserted.
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("reset_outs", {tune, busy, done, rom_addr}, '0);

    // Basic song.
    done_cnt = 0;
    do_start(0);
    wait_idle("basic", 200);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);

    // Loop once, then release loop_en during the second pass.
    done_cnt = 0;
    loop_en = 1'b1;
    do_start(1);
    repeat (100) @(posedge clk);
    #1 loop_en = 1'b0;
    wait_idle("loop", 200);
    check("loop_done_cnt", 32'(done_cnt), 32'd1);

    // Stop mid-note at cycle 15, restart at cycle 20.
    done_cnt = 0;
    do_start(0);
    repeat (13) @(posedge clk);
    do_stop();
    check("stop_outs", {tune, busy}, 9'd0);
    repeat (3) @(posedge clk);
    do_start(0);
    repeat (2) @(posedge clk); #1;
    check("restart_tune", 32'(tune), 32'h11);
    pulse(1'b1, 1'b0);
    wait_idle("restart", 200);
    check("stop_done_cnt", 32'(done_cnt), 32'd1);

    // start with stop in the same cycle stays idle; stop in DECODE and in the gap window.
    done_cnt = 0;
    pulse(1'b1, 1'b1);
    check("start_stop_idle", 32'(busy), 32'd0);
    do_start(0);
    do_stop();
    check("stop_decode", 32'(busy), 32'd0);
    do_start(0);
    repeat (29) @(posedge clk);
    do_stop();
    repeat (2) @(posedge clk);
    check("stop_no_done", 32'(done_cnt), 32'd0);

    // Full ROM without sentinel.
    done_cnt = 0;
    set_rom(16'h1101, 16'h1201, 16'h1301, 16'h1401);
    do_start(0);
    wait_idle("full_rom", 100);
    check("full_done_cnt", 32'(done_cnt), 32'd1);

    // Longest note.
    done_cnt = 0;
    set_rom(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    do_start(0);
    wait_idle("long_note", 2700);
    check("long_done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
